// File: rtl/mxrv_if_fetch_pkg.sv
// mxrv_if_fetch_pkg: fetch-path constants and helpers that decode and the bus adapter also use
package mxrv_if_fetch_pkg;
   localparam int ADDR_W_DEF   = 32;
   localparam int DATA_W_DEF   = 32;
   localparam int RESET_PC_DEF = 0;
   function automatic int fetch_step(input int data_w);
      return data_w / 8;
   endfunction
   // FIFO entry layout, MSB first: {pc, instruction word, error flag}
   function automatic int entry_w(input int addr_w, input int data_w);
      return addr_w + data_w + 1;
   endfunction
endpackage

// File: rtl/mxrv_if_fetch_if.sv
// mxrv_if_fetch_if: control, instruction-bus and decode-side signals of the fetch unit
interface mxrv_if_fetch_if
   import mxrv_if_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              hold_i;
   logic              jump_en_i;
   logic [ADDR_W-1:0] jump_addr_i;
   logic              req_valid_o;
   logic [ADDR_W-1:0] req_addr_o;
   logic              req_ready_i;
   logic              rsp_valid_i;
   logic [DATA_W-1:0] rsp_data_i;
   logic              rsp_err_i;
   logic              inst_valid_o;
   logic [DATA_W-1:0] inst_o;
   logic [ADDR_W-1:0] inst_pc_o;
   logic              inst_err_o;
   logic              inst_ready_i;
   modport master (
      input  hold_i, jump_en_i, jump_addr_i, req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i, inst_ready_i,
      output req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o
   );
   modport slave (
      output hold_i, jump_en_i, jump_addr_i, req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i, inst_ready_i,
      input  req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o
   );
endinterface

// File: rtl/mxrv_if_fifo.sv
// mxrv_if_fifo: small synchronous FIFO, flush dominant, head reads as zero when empty
module mxrv_if_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr, rd;
   logic             do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & !full & !flush;
   assign do_pop  = pop & !empty & !flush;
   assign dout    = empty ? '0 : mem[rd];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else if (flush) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         wr    <= do_push ? wr + 1'b1 : wr;
         rd    <= do_pop ? rd + 1'b1 : rd;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr] <= din;
endmodule

// File: rtl/mxrv_if_fetch.sv
// mxrv_if_fetch: PC owner issuing in-order word fetches, buffering responses toward decode
module mxrv_if_fetch
   import mxrv_if_fetch_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter int                DATA_W     = DATA_W_DEF,
   parameter int                FIFO_DEPTH = 2,
   parameter int                MAX_OUTST  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
   input logic            clk,
   input logic            rst,
   mxrv_if_fetch_if.master bus
);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(fetch_step(DATA_W));
   localparam int EW = entry_w(ADDR_W, DATA_W);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   logic [ADDR_W-1:0] pc, rsp_pc, jump_pc;
   logic [OW-1:0]     outst, outst_next, discard;
   logic [CW-1:0]     count;
   logic [EW-1:0]     head;
   logic              full, empty, accept, push;
   assign jump_pc = bus.jump_addr_i & ~(STEP - 1'b1);
   // credit covers both in-flight requests and buffered entries, so a landing response always fits
   assign bus.req_valid_o = !rst && !bus.hold_i && !bus.jump_en_i && (discard == '0)
                            && (int'(outst) < MAX_OUTST) && (int'(outst) + int'(count) < FIFO_DEPTH);
   assign bus.req_addr_o  = pc;
   assign accept     = bus.req_valid_o & bus.req_ready_i;
   assign push       = bus.rsp_valid_i & (discard == '0) & !bus.jump_en_i;
   assign outst_next = outst + OW'(accept) - OW'(bus.rsp_valid_i);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc      <= RESET_PC;
         rsp_pc  <= RESET_PC;
         outst   <= '0;
         discard <= '0;
      end else begin
         outst   <= outst_next;
         pc      <= bus.jump_en_i ? jump_pc : accept ? pc + STEP : pc;
         rsp_pc  <= bus.jump_en_i ? jump_pc : push ? rsp_pc + STEP : rsp_pc;
         discard <= bus.jump_en_i ? outst_next : (bus.rsp_valid_i && discard != '0) ? discard - 1'b1 : discard;
      end
   mxrv_if_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (bus.inst_valid_o & bus.inst_ready_i),
      .flush (bus.jump_en_i),
      .din   ({rsp_pc, bus.rsp_data_i, bus.rsp_err_i}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   assign bus.inst_valid_o = !empty;
   assign {bus.inst_pc_o, bus.inst_o, bus.inst_err_o} = head;
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(bus.rsp_valid_i && discard == '0 && full));
endmodule

// File: tb/tb_mxrv_if_fetch.sv
// tb_mxrv_if_fetch: directed scenarios plus random traffic against a queue-based fetch model
module tb_mxrv_if_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   mxrv_if_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mxrv_if_fetch #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2), .MAX_OUTST(2), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   typedef struct {
      logic [31:0] pc;
      logic [31:0] d;
      logic        e;
   } ent_t;
   ent_t        fq[$];
   logic [31:0] bq[$];
   logic [31:0] mpc;
   int          stale;
   int          n_cmp = 0;
   int          n_bad = 0;
   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, o, e);
      end
   endtask
   task automatic drive_idle();
      bus.hold_i = 0; bus.jump_en_i = 0; bus.jump_addr_i = '0; bus.req_ready_i = 0;
      bus.rsp_valid_i = 0; bus.rsp_data_i = '0; bus.rsp_err_i = 0; bus.inst_ready_i = 0;
   endtask
   task automatic chk_reset();
      chk("rst_req_valid", bus.req_valid_o, 0);
      chk("rst_req_addr", bus.req_addr_o, 0);
      chk("rst_inst_valid", bus.inst_valid_o, 0);
      chk("rst_inst", bus.inst_o, 0);
      chk("rst_inst_pc", bus.inst_pc_o, 0);
      chk("rst_inst_err", bus.inst_err_o, 0);
   endtask
   task automatic do_reset();
      rst = 1;
      drive_idle();
      #1 chk_reset();
      @(posedge clk);
      #1 rst = 0;
      fq.delete(); bq.delete(); mpc = 0; stale = 0;
   endtask
   // one clock cycle: drive, compare against the model, advance the model
   task automatic step(input logic h, input logic j, input logic [31:0] ja, input logic rr,
                       input logic rv, input logic [31:0] rd, input logic re, input logic ir);
      logic        exp_rv, acc, pop, rsp;
      logic [31:0] a;
      rsp = rv && bq.size() > 0;
      bus.hold_i = h; bus.jump_en_i = j; bus.jump_addr_i = ja; bus.req_ready_i = rr;
      bus.rsp_valid_i = rsp; bus.rsp_data_i = rd; bus.rsp_err_i = re; bus.inst_ready_i = ir;
      #1;
      exp_rv = !h && !j && stale == 0 && bq.size() < 2 && bq.size() + fq.size() < 2;
      chk("req_valid", bus.req_valid_o, exp_rv);
      if (exp_rv) chk("req_addr", bus.req_addr_o, mpc);
      chk("inst_valid", bus.inst_valid_o, fq.size() > 0);
      if (fq.size() > 0) begin
         chk("inst_pc", bus.inst_pc_o, fq[0].pc);
         chk("inst", bus.inst_o, fq[0].d);
         chk("inst_err", bus.inst_err_o, fq[0].e);
      end
      acc = exp_rv && rr;
      pop = fq.size() > 0 && ir && !j;
      if (pop) void'(fq.pop_front());
      if (rsp) begin
         a = bq.pop_front();
         if (stale > 0) stale--;
         else if (!j) fq.push_back('{a, rd, re});
      end
      if (acc) begin
         bq.push_back(mpc);
         mpc += 32'd4;
      end
      if (j) begin
         fq.delete();
         mpc = ja & ~32'h3;
         stale = bq.size();
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      do_reset();
      // streaming at full rate, first delivery two cycles after first accept
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, $urandom, 0, 1);
      // decode stalled: buffer fills, issue stops, then drains and resumes
      do_reset();
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, $urandom, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, $urandom, 0, 1);
      // jump with two stale requests in flight
      do_reset();
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 32'h103, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, $urandom, 0, 0);
      step(0, 0, 0, 1, 1, $urandom, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, $urandom, 0, 0);
      chk("jump_head_pc", bus.inst_pc_o, 32'h100);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, $urandom, 0, 1);
      // jump coinciding with the only outstanding response
      do_reset();
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 32'h100, 0, 1, $urandom, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, $urandom, 0, 1);
      // hold with one request outstanding
      do_reset();
      step(0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1, $urandom, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, $urandom, 0, 1);
      // error response on PC 0x8, then reset mid-stream
      do_reset();
      for (int i = 0; i < 10; i++)
         step(0, 0, 0, 1, 1, $urandom, (bq.size() > 0 && bq[0] == 32'h8), 1);
      do_reset();
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic j;
         j = ($urandom % 16) == 0;
         step(($urandom % 4) == 0, j, $urandom, ($urandom % 4) != 0, ($urandom % 3) != 0,
              $urandom, ($urandom % 8) == 0, !j && ($urandom % 3) != 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mxrv_if_fetch.md
Name: mxrv_if_fetch

Overview:
Parametrised instruction-fetch unit: owns the PC, issues in-order word requests on a valid/ready instruction bus, and buffers returned instructions with their PC in a small prefetch FIFO toward decode. It handles jump redirects by discarding in-flight responses, and handles hold and decode back-pressure. It sits between the PC/control logic (hold, jump) and the decode stage.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width (fetch step = DATA_W/8 bytes)
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)
MAX_OUTST, 2, maximum accepted-but-unanswered bus requests (>=1)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock; all state is on the rising edge
rst  in  1  asynchronous, active-high reset
hold_i  in  1  stop issuing new bus requests
jump_en_i  in  1  one-cycle redirect strobe
jump_addr_i  in  ADDR_W  redirect target
req_valid_o  out  1  bus request valid
req_addr_o  out  ADDR_W  bus request address
req_ready_i  in  1  bus accepts request
rsp_valid_i  in  1  bus response valid (in order, one per accepted request)
rsp_data_i  in  DATA_W  instruction word
rsp_err_i  in  1  bus error for this response
inst_valid_o  out  1  FIFO head valid to decode
inst_o  out  DATA_W  instruction at head
inst_pc_o  out  ADDR_W  PC of head instruction
inst_err_o  out  1  fetch-error flag of head
inst_ready_i  in  1  decode consumes head

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; rsp_pc=RESET_PC; outst=0; discard=0; FIFO empty. req_valid_o=0, req_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_err_o=0. Reset mid-transaction drops everything; the bus owner must also be reset.
- The low log2(DATA_W/8) bits of jump_addr_i are forced to 0.
- Issue: req_valid_o = !hold_i & !jump_en_i & (discard==0) & (outst < MAX_OUTST) & (outst + fifo_count < FIFO_DEPTH). req_addr_o = pc.
- A request is accepted when req_valid_o & req_ready_i; then pc += DATA_W/8 and outst += 1. PC wraps modulo 2^ADDR_W.
- Response: on rsp_valid_i, outst -= 1. If discard>0: discard -= 1 and the response is dropped. Otherwise {rsp_pc, rsp_data_i, rsp_err_i} is written to the FIFO and rsp_pc += DATA_W/8.
- Simultaneous accept and response in one cycle: outst is unchanged.
- Credit rule means the FIFO can never overflow. A response arriving with the FIFO full and discard==0 is a protocol violation; assert it in simulation.
- Output: FIFO head drives inst_*; registered, no bypass. Minimum latency: request accepted in cycle t, response in t+1, inst_valid_o in t+2. A pop happens when inst_valid_o & inst_ready_i.
- Jump (priority over everything):
  - In the jump_en_i cycle: pc, rsp_pc <= jump_addr; FIFO flushed, including any same-cycle pop or write; req_valid_o=0.
  - discard <= outst_next, i.e. outstanding count after this cycle's response is applied.
  - Issue resumes once discard==0.
  - A jump while discard>0 reloads discard the same way.
- hold_i: blocks new requests only. Outstanding responses still land, and the FIFO still drains to decode.
- rsp_err_i entries are delivered in order with inst_err_o=1. The fetch unit does not stop fetching; the trap decision belongs to later stages.
- Boundaries:
  - FIFO full: issue stalls.
  - FIFO empty: inst_valid_o=0.
  - MAX_OUTST reached: issue stalls.
  - Back-to-back jumps: the last one wins.

Decomposition:
- Shared defines file: fetch step (DATA_W/8), default RESET_PC, and FIFO entry field widths. These are reused by decode and the bus adapter.
- One sub-module, mxrv_if_fifo: synchronous FIFO with parameter WIDTH and DEPTH, async active-high reset, ports push/pop/flush/full/empty/count, and flush dominant.
- Counters and PC logic stay in mxrv_if_fetch.

Test Plan:
- Reset release, req_ready_i=1, bus answers 1 cycle later, inst_ready_i=1 -> requests 0x0,0x4,0x8...; first inst_valid_o two cycles after first accept, inst_pc_o=0x0.
- inst_ready_i=0, FIFO_DEPTH=2 -> exactly 2 requests accepted, then req_valid_o=0. Raise inst_ready_i -> pops 0x0, 0x4 and issue resumes at 0x8.
- Two requests outstanding (0x10, 0x14), jump_en_i to 0x103 -> next request addr 0x100 only after both stale responses are dropped; first delivered inst_pc_o=0x100.
- Jump in the same cycle as a response with outst=1 -> discard=0, the response is dropped via flush, and issue of 0x100 starts the next cycle.
- hold_i=1 for 5 cycles with 1 outstanding -> no new requests; pending response still delivered; issue resumes the cycle after hold_i falls.
- rsp_err_i=1 on PC 0x8 -> inst_err_o=1 with inst_pc_o=0x8; next entry 0xC has err=0; assert rst mid-stream -> all outputs return to reset values immediately.
